// File: rtl/lbc_wbuf_gen_if.sv
// rtl/lbc_wbuf_gen_if.sv - store write buffer bus: core push side, load hit check, flush and drain port
interface lbc_wbuf_gen_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int BW = DW / 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          WB_PUSH;
  logic [AW-1:0] WB_PADDR;
  logic [DW-1:0] WB_PDATA;
  logic [BW-1:0] WB_PBE;
  logic          WB_FULL;
  logic          WB_EMPTY;
  logic [CW-1:0] WB_COUNT;
  logic          WB_OVF;
  logic [AW-1:0] WB_CHKADDR;
  logic          WB_HIT;
  logic          WB_DISABLE;
  logic          WB_FLUSH;
  logic          WB_FLUSHDONE;
  logic          WB_DVALID;
  logic [AW-1:0] WB_DADDR;
  logic [DW-1:0] WB_DDATA;
  logic [BW-1:0] WB_DBE;
  logic          WB_DACK;

  modport master (
    output WB_PUSH, WB_PADDR, WB_PDATA, WB_PBE, WB_CHKADDR, WB_DISABLE, WB_FLUSH, WB_DACK,
    input  WB_FULL, WB_EMPTY, WB_COUNT, WB_OVF, WB_HIT, WB_FLUSHDONE,
           WB_DVALID, WB_DADDR, WB_DDATA, WB_DBE
  );

  modport slave (
    input  WB_PUSH, WB_PADDR, WB_PDATA, WB_PBE, WB_CHKADDR, WB_DISABLE, WB_FLUSH, WB_DACK,
    output WB_FULL, WB_EMPTY, WB_COUNT, WB_OVF, WB_HIT, WB_FLUSHDONE,
           WB_DVALID, WB_DADDR, WB_DDATA, WB_DBE
  );
endinterface

// File: rtl/lbc_wbuf_gen.sv
// rtl/lbc_wbuf_gen.sv - parametrised store write buffer with merging, load hit check and flush
module lbc_wbuf_gen #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int MERGE = 1
) (
  input logic SYSCLK,
  input logic RESET_D1_R_N,
  lbc_wbuf_gen_if.slave wb
);
  localparam int BW = DW / 8;
  localparam int OB = $clog2(BW);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WA = AW - OB;

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  state_t        state;
  logic          flushdone_q;

  logic [WA-1:0]    mem_addr [DEPTH];
  logic [DW-1:0]    mem_data [DEPTH];
  logic [BW-1:0]    mem_be   [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             dis_q;
  logic             ovf_q;

  logic [PW-1:0] young_ptr;
  logic [CW-1:0] eff_depth;
  logic [WA-1:0] push_waddr;
  logic [DW-1:0] be_mask;
  logic          full;
  logic          empty;
  logic          pop;
  logic          do_merge;
  logic          do_alloc;
  logic          drop;
  logic          hit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Disable is registered so FULL and the merge decision depend only on state.
  always_comb begin
    eff_depth  = dis_q ? CW'(1) : CW'(DEPTH);
    empty      = (count == '0);
    full       = (state == ST_FLUSH) || (count >= eff_depth);
    pop        = !empty && wb.WB_DACK;
    young_ptr  = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - PW'(1);
    push_waddr = wb.WB_PADDR[AW-1:OB];
    do_merge   = (MERGE != 0) && !dis_q && (state == ST_IDLE) && (count >= CW'(2)) &&
                 wb.WB_PUSH && (mem_addr[young_ptr] == push_waddr);
    do_alloc   = wb.WB_PUSH && !do_merge && !full;
    drop       = wb.WB_PUSH && !do_merge && full;
  end

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < BW; b++) begin
      be_mask[8*b +: 8] = {8{wb.WB_PBE[b]}};
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (mem_addr[i] == wb.WB_CHKADDR[AW-1:OB])) begin
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!RESET_D1_R_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
      dis_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      dis_q <= wb.WB_DISABLE;
      if (drop) begin
        ovf_q <= 1'b1;
      end
      if (do_alloc) begin
        mem_addr[wr_ptr] <= push_waddr;
        mem_data[wr_ptr] <= wb.WB_PDATA & be_mask;
        mem_be[wr_ptr]   <= wb.WB_PBE;
        valid[wr_ptr]    <= 1'b1;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      // Merge target is the youngest entry, which is never the head when count >= 2.
      if (do_merge) begin
        mem_data[young_ptr] <= (mem_data[young_ptr] & ~be_mask) | (wb.WB_PDATA & be_mask);
        mem_be[young_ptr]   <= mem_be[young_ptr] | wb.WB_PBE;
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= ptr_inc(rd_ptr);
      end
      if (do_alloc && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !do_alloc) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!RESET_D1_R_N) begin
      state       <= ST_IDLE;
      flushdone_q <= 1'b0;
    end else begin
      flushdone_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (wb.WB_FLUSH) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (count == '0) begin
            state       <= ST_IDLE;
            flushdone_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  generate
    if (OB > 0) begin : g_unused_lo
      logic unused_lo;
      assign unused_lo = ^{wb.WB_PADDR[OB-1:0], wb.WB_CHKADDR[OB-1:0]};
    end
  endgenerate

  assign wb.WB_FULL      = full;
  assign wb.WB_EMPTY     = empty;
  assign wb.WB_COUNT     = count;
  assign wb.WB_OVF       = ovf_q;
  assign wb.WB_HIT       = hit;
  assign wb.WB_FLUSHDONE = flushdone_q;
  assign wb.WB_DVALID    = !empty;
  assign wb.WB_DADDR     = empty ? '0 : (AW'(mem_addr[rd_ptr]) << OB);
  assign wb.WB_DDATA     = empty ? '0 : mem_data[rd_ptr];
  assign wb.WB_DBE       = empty ? '0 : mem_be[rd_ptr];
endmodule

// File: tb/tb_lbc_wbuf_gen.sv
// tb/tb_lbc_wbuf_gen.sv - directed bench for lbc_wbuf_gen, with a MERGE=0 twin on mirrored inputs
module tb_lbc_wbuf_gen;
  logic sysclk = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass = 0;
  int   n_chk  = 0;

  always #5 sysclk = ~sysclk;

  lbc_wbuf_gen_if #(.DEPTH(4), .AW(32), .DW(32)) wb ();
  lbc_wbuf_gen_if #(.DEPTH(4), .AW(32), .DW(32)) wb_nm ();

  lbc_wbuf_gen #(.DEPTH(4), .AW(32), .DW(32), .MERGE(1)) dut (
    .SYSCLK(sysclk), .RESET_D1_R_N(reset_n), .wb(wb)
  );
  lbc_wbuf_gen #(.DEPTH(4), .AW(32), .DW(32), .MERGE(0)) dut_nm (
    .SYSCLK(sysclk), .RESET_D1_R_N(reset_n), .wb(wb_nm)
  );

  assign wb_nm.WB_PUSH    = wb.WB_PUSH;
  assign wb_nm.WB_PADDR   = wb.WB_PADDR;
  assign wb_nm.WB_PDATA   = wb.WB_PDATA;
  assign wb_nm.WB_PBE     = wb.WB_PBE;
  assign wb_nm.WB_CHKADDR = wb.WB_CHKADDR;
  assign wb_nm.WB_DISABLE = wb.WB_DISABLE;
  assign wb_nm.WB_FLUSH   = wb.WB_FLUSH;
  assign wb_nm.WB_DACK    = wb.WB_DACK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge sysclk);
    #2;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wb.WB_PUSH  = 1'b1;
    wb.WB_PADDR = a;
    wb.WB_PDATA = d;
    wb.WB_PBE   = be;
    tick();
    wb.WB_PUSH  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int done_cnt;
    int done_count_val;
    int full_bad;
    int fd_seen;

    wb.WB_PUSH = 0; wb.WB_PADDR = 0; wb.WB_PDATA = 0; wb.WB_PBE = 0;
    wb.WB_CHKADDR = 0; wb.WB_DISABLE = 0; wb.WB_FLUSH = 0; wb.WB_DACK = 0;
    do_reset();

    chk("rst_empty", wb.WB_EMPTY, 1);
    chk("rst_full", wb.WB_FULL, 0);
    chk("rst_count", wb.WB_COUNT, 0);
    chk("rst_dvalid", wb.WB_DVALID, 0);
    chk("rst_ovf", wb.WB_OVF, 0);
    chk("rst_hit", wb.WB_HIT, 0);
    chk("rst_fdone", wb.WB_FLUSHDONE, 0);
    chk("rst_daddr", wb.WB_DADDR, 0);

    // fill / drain
    for (int i = 0; i < 4; i++) push(32'h100 + 4*i, 32'hA000 + i, 4'hF);
    chk("fill_count", wb.WB_COUNT, 4);
    chk("fill_full", wb.WB_FULL, 1);
    chk("fill_head", wb.WB_DADDR, 32'h100);
    push(32'h110, 32'hBEEF, 4'hF);
    chk("ovf_set", wb.WB_OVF, 1);
    chk("ovf_count", wb.WB_COUNT, 4);
    wb.WB_DACK = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_addr", wb.WB_DADDR, 32'h100 + 4*i);
      chk("drain_data", wb.WB_DDATA, 32'hA000 + i);
      tick();
    end
    wb.WB_DACK = 1'b0;
    chk("drain_empty", wb.WB_EMPTY, 1);
    chk("drain_ddata0", wb.WB_DDATA, 0);

    // merge vs no-merge twin
    do_reset();
    push(32'h200, 32'h0000_0011, 4'b0001);
    push(32'h204, 32'h0000_0022, 4'b0001);
    push(32'h204, 32'h0033_0000, 4'b0100);
    chk("merge_count", wb.WB_COUNT, 2);
    chk("nomerge_count", wb_nm.WB_COUNT, 3);
    wb.WB_DACK = 1'b1;
    chk("m_h0_addr", wb.WB_DADDR, 32'h200);
    chk("m_h0_data", wb.WB_DDATA, 32'h11);
    chk("nm_h0_addr", wb_nm.WB_DADDR, 32'h200);
    tick();
    chk("m_h1_addr", wb.WB_DADDR, 32'h204);
    chk("m_h1_data", wb.WB_DDATA, 32'h0033_0022);
    chk("m_h1_be", wb.WB_DBE, 4'b0101);
    chk("nm_h1_data", wb_nm.WB_DDATA, 32'h22);
    chk("nm_h1_be", wb_nm.WB_DBE, 4'b0001);
    tick();
    chk("m_empty", wb.WB_EMPTY, 1);
    chk("nm_h2_data", wb_nm.WB_DDATA, 32'h0033_0000);
    chk("nm_h2_be", wb_nm.WB_DBE, 4'b0100);
    tick();
    chk("nm_empty", wb_nm.WB_EMPTY, 1);
    wb.WB_DACK = 1'b0;

    // head entry is never a merge target
    push(32'h300, 32'h1, 4'b0001);
    push(32'h300, 32'h200, 4'b0010);
    chk("head_nomerge_count", wb.WB_COUNT, 2);
    chk("head_data", wb.WB_DDATA, 32'h1);
    wb.WB_DACK = 1'b1;
    tick();
    chk("head2_addr", wb.WB_DADDR, 32'h300);
    chk("head2_data", wb.WB_DDATA, 32'h200);
    tick();
    chk("head_empty", wb.WB_EMPTY, 1);
    wb.WB_DACK = 1'b0;

    // load hit check
    push(32'h400, 32'h4, 4'hF);
    push(32'h408, 32'h8, 4'hF);
    wb.WB_CHKADDR = 32'h40B; #1;
    chk("hit_40b", wb.WB_HIT, 1);
    wb.WB_CHKADDR = 32'h404; #1;
    chk("hit_404", wb.WB_HIT, 0);
    wb.WB_CHKADDR = 32'h400; wb.WB_DACK = 1'b1; #1;
    chk("hit_during_ack", wb.WB_HIT, 1);
    tick();
    chk("hit_after_pop", wb.WB_HIT, 0);
    tick();
    wb.WB_DACK = 1'b0;
    chk("hit_empty", wb.WB_EMPTY, 1);

    // flush with an empty buffer
    wb.WB_FLUSH = 1'b1;
    tick();
    wb.WB_FLUSH = 1'b0;
    chk("eflush_full", wb.WB_FULL, 1);
    chk("eflush_nodone", wb.WB_FLUSHDONE, 0);
    tick();
    chk("eflush_done", wb.WB_FLUSHDONE, 1);
    chk("eflush_idle_full", wb.WB_FULL, 0);
    tick();
    chk("eflush_pulse", wb.WB_FLUSHDONE, 0);

    // flush with 3 entries and acks every other cycle
    push(32'h500, 32'h5, 4'hF);
    push(32'h504, 32'h6, 4'hF);
    push(32'h508, 32'h7, 4'hF);
    chk("pre_flush_ovf", wb.WB_OVF, 0);
    wb.WB_FLUSH = 1'b1;
    tick();
    wb.WB_FLUSH = 1'b0;
    done_cnt = 0; done_count_val = -1; full_bad = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (wb.WB_FLUSHDONE) begin
        done_cnt++;
        done_count_val = int'(wb.WB_COUNT);
      end else if (done_cnt == 0 && !wb.WB_FULL) begin
        full_bad++;
      end
      wb.WB_DACK  = cyc[0];
      wb.WB_PUSH  = (cyc == 1);
      wb.WB_PADDR = 32'h600;
      wb.WB_PBE   = 4'hF;
      tick();
    end
    wb.WB_PUSH = 1'b0;
    wb.WB_DACK = 1'b0;
    chk("flush_done_once", done_cnt, 1);
    chk("flush_done_count", done_count_val, 0);
    chk("flush_full_held", full_bad, 0);
    chk("flush_drop_ovf", wb.WB_OVF, 1);
    chk("flush_empty", wb.WB_EMPTY, 1);

    // disable mode
    do_reset();
    push(32'h700, 32'h1, 4'hF);
    push(32'h704, 32'h2, 4'hF);
    push(32'h708, 32'h3, 4'hF);
    wb.WB_DISABLE = 1'b1;
    tick();
    chk("dis_full", wb.WB_FULL, 1);
    push(32'h70C, 32'h4, 4'hF);
    chk("dis_drop_count", wb.WB_COUNT, 3);
    chk("dis_drop_ovf", wb.WB_OVF, 1);
    wb.WB_DACK = 1'b1;
    tick(); tick(); tick();
    wb.WB_DACK = 1'b0;
    chk("dis_drained", wb.WB_EMPTY, 1);
    chk("dis_notfull", wb.WB_FULL, 0);
    push(32'h710, 32'h10, 4'hF);
    chk("dis_one", wb.WB_COUNT, 1);
    push(32'h714, 32'h14, 4'hF);
    chk("dis_max1", wb.WB_COUNT, 1);
    chk("dis_head", wb.WB_DADDR, 32'h710);
    wb.WB_DACK = 1'b1;
    tick();
    wb.WB_DACK = 1'b0;
    wb.WB_DISABLE = 1'b0;
    tick();

    // reset mid-drain
    push(32'h800, 32'h8, 4'hF);
    push(32'h804, 32'h9, 4'hF);
    wb.WB_DACK = 1'b1;
    tick();
    chk("pre_rst_count", wb.WB_COUNT, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    wb.WB_DACK = 1'b0;
    chk("mid_rst_empty", wb.WB_EMPTY, 1);
    chk("mid_rst_dvalid", wb.WB_DVALID, 0);
    chk("mid_rst_ovf", wb.WB_OVF, 0);

    // reset during flush gives no done pulse
    push(32'h900, 32'h9, 4'hF);
    wb.WB_FLUSH = 1'b1;
    tick();
    wb.WB_FLUSH = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    fd_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (wb.WB_FLUSHDONE) fd_seen++;
      tick();
    end
    chk("abort_flush_nodone", fd_seen, 0);
    chk("abort_flush_notfull", wb.WB_FULL, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lbc_wbuf_gen.md
# lbc_wbuf_gen

Parametrised store write buffer for the local bus controller, in the SYSCLK domain between the core data port and the downstream bus request logic. It accepts byte-enabled stores, optionally merges consecutive stores to the same word, and drains entries in order through a valid/ack port. It also reports load-address hits against pending entries and supports a flush handshake. Compared with the fixed write buffer, depth, address width, data width, merging and disable mode are all generalised.

## Interface
- DEPTH, 4: number of entries, 2..16.
- AW, 32: address width.
- DW, 32: data width, a multiple of 8; BW = DW/8 byte lanes; OB = log2(BW) byte-offset bits.
- MERGE, 1: 1 enables store merging; 0 disables it.

- SYSCLK  in  1  single clock, rising edge.
- RESET_D1_R_N  in  1  reset, synchronous, active-low.
- WB_PUSH  in  1  store request.
- WB_PADDR  in  AW  store byte address; bits [OB-1:0] are ignored.
- WB_PDATA  in  DW  store data.
- WB_PBE  in  BW  store byte enables.
- WB_FULL  out  1  push will not be accepted this cycle (merge excepted).
- WB_EMPTY  out  1  no valid entries.
- WB_COUNT  out  log2(DEPTH)+1  valid entry count.
- WB_OVF  out  1  sticky: a push was dropped.
- WB_CHKADDR  in  AW  load address for hit check.
- WB_HIT  out  1  combinational: some valid entry matches the word address of WB_CHKADDR.
- WB_DISABLE  in  1  buffering disabled: effective depth 1, no merging.
- WB_FLUSH  in  1  flush request pulse.
- WB_FLUSHDONE  out  1  one-cycle pulse when the flush completes.
- WB_DVALID  out  1  head entry presented.
- WB_DADDR  out  AW  head word address, with low OB bits forced to 0.
- WB_DDATA  out  DW  head data.
- WB_DBE  out  BW  head byte enables.
- WB_DACK  in  1  head consumed.

## Operation
- **Storage.** Circular FIFO with write pointer, read pointer and count. Pointers wrap at DEPTH-1 → 0.
- **Effective depth.** ED = 1 when WB_DISABLE=1, otherwise DEPTH.
- **WB_FULL.** Asserted when count ≥ ED, or when the FSM is in FLUSH.
  - Disable asserted while count > 1: nothing is lost. Existing entries drain, and WB_FULL holds until count < 1.
- **Merge condition.** MERGE=1, WB_DISABLE=0, state IDLE, count ≥ 2, and WB_PADDR[AW-1:OB] equals the youngest entry's word address.
- **Merge action.** For each lane with WB_PBE=1, overwrite that data byte and set that BE bit in the youngest entry. Count is unchanged.
- **Head never merged.** The head entry is never a merge target (count=1 never merges), because it may already be presented.
- **Push.**
  - Merge condition true: merge.
  - Otherwise, !WB_FULL: allocate at the write pointer; count+1.
  - Otherwise: drop the push and set WB_OVF. WB_OVF clears only on reset.
- **Pop.** On WB_DVALID & WB_DACK: advance the read pointer; count-1.
  - Push and pop in the same cycle: count is unchanged.
  - WB_FULL is computed from the start-of-cycle count, so a push while count=ED is dropped even if a pop occurs in the same cycle.
- **WB_HIT.** OR over valid entries of (entry word address == WB_CHKADDR[AW-1:OB]).
  - Includes the head entry.
  - Includes an entry being popped in the current cycle.
- **Flush FSM.** Two states, IDLE and FLUSH.
  - IDLE → FLUSH on WB_FLUSH.
  - FLUSH → IDLE when count = 0. WB_FLUSHDONE pulses on that transition cycle.
  - WB_FLUSH while in FLUSH is ignored.
  - Flush with an empty buffer: FLUSH for 1 cycle, WB_FLUSHDONE on the next cycle.
- **Drain outputs.** WB_DADDR, WB_DDATA and WB_DBE are driven to 0 when WB_EMPTY=1.

## Timing
- **Reset values.** Pointers 0, count 0, WB_FULL 0, WB_EMPTY 1, WB_DVALID 0, WB_FLUSHDONE 0, WB_OVF 0, WB_HIT 0, drain data 0, FSM IDLE.
- **Reset mid-operation.** All entries are discarded at the reset edge. No WB_FLUSHDONE is issued for an aborted flush.
- **Push-to-drain latency.** A push accepted at edge N gives WB_DVALID=1 from cycle N+1, with that entry's contents if it is the head.
- **Merge visibility.**
  - A merge at edge N is visible on WB_HIT and in storage from cycle N+1.
  - A merge can never change the presented head.
- **Drain handshake.**
  - WB_DVALID stays high and the head is stable until WB_DACK.
  - WB_DACK while WB_DVALID=0 is ignored.
- **Output sources.**
  - WB_FULL, WB_EMPTY, WB_COUNT and WB_DVALID are derived from registered state only.
  - WB_HIT is the only combinational input-to-output path.

## Test plan
- **Fill/drain.** DEPTH=4, WB_DACK=0. Push addresses 0x100, 0x104, 0x108, 0x10C → WB_COUNT=4, WB_FULL=1. Fifth push 0x110 → WB_OVF=1, count stays 4. Then WB_DACK=1 → drained in order 0x100..0x10C, WB_EMPTY=1 after 4 cycles.
- **Merge.** Push 0x200 BE=0001 data 0x11, then 0x204 BE=0001 data 0x22, then 0x204 BE=0100 data 0x00330000 → count=2. Second drained entry: addr 0x204, data 0x00330022, BE=0101. Repeat with MERGE=0 → count=3.
- **Head not merged.** With one entry at 0x300, push 0x300 again → count=2, both entries drained separately.
- **Hit.** Entries at 0x400 and 0x408. WB_CHKADDR=0x40B → WB_HIT=1; 0x404 → WB_HIT=0. Hit persists during the cycle 0x400 is acked.
- **Flush.** 3 entries, WB_FLUSH pulse, WB_DACK=1 every other cycle → WB_FULL=1 throughout. WB_FLUSHDONE pulses exactly once, in the cycle count reaches 0. Pushes during the flush are dropped with WB_OVF=1.
- **Disable and reset.**
  - WB_DISABLE=1 with 3 entries → pushes rejected until empty, then 1 entry maximum.
  - Reset asserted mid-drain → next cycle WB_EMPTY=1, WB_DVALID=0, WB_OVF=0.
